riscv_crypto_fu_ssha512_msched: RTL and testbench
=================================================

// Module: riscv_crypto_fu_ssha512_msched
//
// PURPOSE
//  SHA-512 message-schedule expander for the upstream side of the ssha512 functional unit.
//  Accepts one 1024-bit block as 16 x 64-bit words W[0..15] and streams all 80 schedule words W[0..79] in order.
//  Recurrence: W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16].
//  Feeds the compression-round datapath; the sig0/sig1 terms come from ssha512 FU instances with XLEN=64.
//
// PARAMETERS
//  NWORDS   80  schedule length emitted per block (fixed by FIPS 180-4; legal value 80 only)
//
// PORTS
//  g_clk      in   1   global clock
//  g_resetn   in   1   asynchronous, active-low reset
//  flush      in   1   synchronous abort; returns to IDLE
//  in_valid   in   1   message word valid
//  in_ready   out  1   message word accepted when in_valid & in_ready
//  in_word    in   64  message word, big-endian word order W[0] first
//  out_valid  out  1   schedule word valid
//  out_ready  in   1   consumer takes word when out_valid & out_ready
//  out_word   out  64  W[out_idx]
//  out_idx    out  7   index t of out_word, 0..79
//  out_last   out  1   high with out_valid when out_idx == 79
//  busy       out  1   high in LOAD or EXPAND
//
// BEHAVIOUR
//  - Reset (g_resetn low, asynchronous): state=IDLE, window w[0..15]=0, counters=0; in_ready=0, out_valid=0, out_idx=0, out_last=0, busy=0.
//    Reset mid-block discards the block; no partial output afterwards.
//  - Window: 16 x 64-bit shift register w[0..15], with w[0] the oldest word.
//  - IDLE: in_ready=1. First in handshake writes w[15] and shifts, sets load_cnt=1, moves to LOAD.
//  - LOAD: in_ready=1. Each handshake does w[i] <= w[i+1] and w[15] <= in_word, then load_cnt++.
//    On the 16th accepted word: in_ready drops the next cycle, t=0, go to EXPAND.
//  - EXPAND: in_ready=0, out_valid=1, out_word=w[0], out_idx=t.
//    out_valid rises exactly 1 cycle after the 16th input handshake.
//    On each out handshake: w[i] <= w[i+1], w[15] <= nw, t++.
//      nw = sig1(w[14]) + w[9] + sig0(w[1]) + w[0], computed mod 2^64 with carries discarded.
//    Handshake at t==79: go to IDLE, out_valid=0 next cycle.
//  - Output stability: while out_valid & !out_ready, out_word/out_idx/out_last hold.
//    Throughput is one word per cycle with no bubbles while out_ready=1.
//  - No input is accepted in EXPAND. A new block may start the cycle after the last output handshake.
//  - flush (any state): next cycle state=IDLE, counters=0, out_valid=0. Window contents are don't-care.
//    flush has priority over simultaneous in/out handshakes.
//  - in_valid while out stream is active is ignored; upstream holds the word.
//  - All outputs are driven from registers or from the state/w[0] registers; no combinational path from in_* to out_*.
//
// STRUCTURE
//  - Shared package riscv_crypto_pkg: SHA512_NWORDS=80, SHA512_BLKWORDS=16, state encoding {IDLE, LOAD, EXPAND}.
//  - Sub-module: two instances of riscv_crypto_fu_ssha512 (XLEN=64).
//    One instance has op_ssha512_sig0=1 with rs1=w[1]; the other has op_ssha512_sig1=1 with rs1=w[14].
//    valid is tied to 1, other op_* inputs are tied to 0, and ready is unused.
//  - Local logic: FSM, 4-bit load_cnt, 7-bit t counter, 16x64 window, one 4-input 64-bit adder.
//
// TESTING
//  1. FIPS "abc" block: W0=0x6162638000000000, W1..14=0, W15=0x18, out_ready=1
//     -> W16=0x6162638000000000, W17=0x00030000000000C0, 80 words, out_last at idx 79.
//  2. Same block, out_ready toggled pseudo-randomly
//     -> identical word sequence; out_word stable while stalled; no drops or duplicates.
//  3. Back-to-back blocks with in_valid held high
//     -> in_ready=0 throughout EXPAND; second block's W0 accepted the cycle after idx 79 handshake.
//  4. Assert g_resetn low at t=40
//     -> all outputs 0 immediately; after release, a fresh block yields correct W0..W79.
//  5. flush at load_cnt=7, then flush during EXPAND with out_ready=1
//     -> IDLE next cycle, out_valid=0, no stray outputs; next block is correct.
//  6. All-ones block W0..15=0xFFFFFFFFFFFFFFFF -> output matches C model including mod-2^64 adder wrap.

Source files
------------

// File: rtl/riscv_crypto_pkg.sv
// Shared definitions for the riscv_crypto functional units: SHA-512 schedule sizes,
// message-schedule FSM encoding and a 64-bit rotate helper.
package riscv_crypto_pkg;

  localparam int unsigned SHA512_NWORDS   = 80;
  localparam int unsigned SHA512_BLKWORDS = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StExpand = 2'd2
  } msched_state_e;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/riscv_crypto_fu_ssha512.sv
// SHA-512 sigma/sum functional unit, XLEN=64 flavour. Single-cycle combinational result;
// the op_* selects are one-hot and an all-zero select yields zero.
module riscv_crypto_fu_ssha512
  import riscv_crypto_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            valid,
  input  logic [XLEN-1:0] rs1,
  input  logic            op_ssha512_sig0,
  input  logic            op_ssha512_sig1,
  input  logic            op_ssha512_sum0,
  input  logic            op_ssha512_sum1,
  output logic            ready,
  output logic [XLEN-1:0] rd
);

  logic [XLEN-1:0] sig0;
  logic [XLEN-1:0] sig1;
  logic [XLEN-1:0] sum0;
  logic [XLEN-1:0] sum1;

  assign sig0 = ror64(rs1, 1)  ^ ror64(rs1, 8)  ^ (rs1 >> 7);
  assign sig1 = ror64(rs1, 19) ^ ror64(rs1, 61) ^ (rs1 >> 6);
  assign sum0 = ror64(rs1, 28) ^ ror64(rs1, 34) ^ ror64(rs1, 39);
  assign sum1 = ror64(rs1, 14) ^ ror64(rs1, 18) ^ ror64(rs1, 41);

  assign rd = ({XLEN{op_ssha512_sig0}} & sig0) |
              ({XLEN{op_ssha512_sig1}} & sig1) |
              ({XLEN{op_ssha512_sum0}} & sum0) |
              ({XLEN{op_ssha512_sum1}} & sum1);

  assign ready = valid;

endmodule

// File: rtl/riscv_crypto_fu_ssha512_msched.sv
// SHA-512 message-schedule expander: loads 16 words into a sliding window and streams
// W[0..79] one per cycle, generating W[t+16] as each word leaves the window.
module riscv_crypto_fu_ssha512_msched
  import riscv_crypto_pkg::*;
#(
  parameter int unsigned NWORDS = SHA512_NWORDS
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_word,
  output logic [6:0]  out_idx,
  output logic        out_last,
  output logic        busy
);

  msched_state_e state_q, state_d;
  logic [3:0]    load_cnt_q, load_cnt_d;
  logic [6:0]    t_q, t_d;
  logic          in_ready_q, in_ready_d;
  logic [63:0]   w_q [SHA512_BLKWORDS];

  logic          shift_en;
  logic [63:0]   shift_in;
  logic [63:0]   sig0_w1;
  logic [63:0]   sig1_w14;
  logic [63:0]   nw;
  logic          in_hs;
  logic          out_hs;
  logic          last_idx;
  logic          unused_ready_sig0;
  logic          unused_ready_sig1;

  riscv_crypto_fu_ssha512 #(
    .XLEN (64)
  ) u_sig0 (
    .valid           (1'b1),
    .rs1             (w_q[1]),
    .op_ssha512_sig0 (1'b1),
    .op_ssha512_sig1 (1'b0),
    .op_ssha512_sum0 (1'b0),
    .op_ssha512_sum1 (1'b0),
    .ready           (unused_ready_sig0),
    .rd              (sig0_w1)
  );

  riscv_crypto_fu_ssha512 #(
    .XLEN (64)
  ) u_sig1 (
    .valid           (1'b1),
    .rs1             (w_q[14]),
    .op_ssha512_sig0 (1'b0),
    .op_ssha512_sig1 (1'b1),
    .op_ssha512_sum0 (1'b0),
    .op_ssha512_sum1 (1'b0),
    .ready           (unused_ready_sig1),
    .rd              (sig1_w14)
  );

  // W[t+16] from the current window; carries out of bit 63 are dropped.
  assign nw = sig1_w14 + w_q[9] + sig0_w1 + w_q[0];

  assign in_hs    = in_valid & in_ready_q;
  assign out_hs   = out_valid & out_ready;
  assign last_idx = (t_q == 7'(NWORDS - 1));

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    t_d        = t_q;
    in_ready_d = in_ready_q;
    shift_en   = 1'b0;
    shift_in   = in_word;
    if (flush) begin
      state_d    = StIdle;
      load_cnt_d = '0;
      t_d        = '0;
      in_ready_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_d = 1'b1;
          if (in_hs) begin
            shift_en   = 1'b1;
            load_cnt_d = 4'd1;
            state_d    = StLoad;
          end
        end
        StLoad: begin
          in_ready_d = 1'b1;
          if (in_hs) begin
            shift_en   = 1'b1;
            load_cnt_d = load_cnt_q + 4'd1;
            if (load_cnt_q == 4'(SHA512_BLKWORDS - 1)) begin
              state_d    = StExpand;
              t_d        = '0;
              in_ready_d = 1'b0;
            end
          end
        end
        StExpand: begin
          in_ready_d = 1'b0;
          shift_in   = nw;
          if (out_hs) begin
            shift_en = 1'b1;
            if (last_idx) begin
              state_d    = StIdle;
              t_d        = '0;
              in_ready_d = 1'b1;
            end else begin
              t_d = t_q + 7'd1;
            end
          end
        end
        default: begin
          state_d    = StIdle;
          load_cnt_d = '0;
          t_d        = '0;
          in_ready_d = 1'b1;
        end
      endcase
    end
  end

  // in_ready is registered so it reads 0 while reset is held and rises on the first edge after.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= StIdle;
      load_cnt_q <= '0;
      t_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      t_q        <= t_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < SHA512_BLKWORDS; i++) begin
        w_q[i] <= '0;
      end
    end else if (shift_en) begin
      for (int i = 0; i < SHA512_BLKWORDS - 1; i++) begin
        w_q[i] <= w_q[i+1];
      end
      w_q[SHA512_BLKWORDS-1] <= shift_in;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == StExpand);
  assign out_word  = w_q[0];
  assign out_idx   = t_q;
  assign out_last  = out_valid & last_idx;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_riscv_crypto_fu_ssha512_msched.sv
// Self-checking bench for the SHA-512 message-schedule expander: scoreboard of expected
// schedule words built from an independent model of the recurrence.
module tb_riscv_crypto_fu_ssha512_msched;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_word = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_word;
  logic [6:0]  out_idx;
  logic        out_last;
  logic        busy;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct packed {
    logic [63:0] word;
    logic [6:0]  idx;
  } exp_t;

  typedef logic [63:0] blk_t [16];

  exp_t sb_q[$];

  riscv_crypto_fu_ssha512_msched dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] m_sig0(input logic [63:0] x);
    return m_ror(x, 1) ^ m_ror(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] m_sig1(input logic [63:0] x);
    return m_ror(x, 19) ^ m_ror(x, 61) ^ (x >> 6);
  endfunction

  task automatic push_expected(input blk_t b);
    logic [63:0] w [80];
    exp_t e;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) w[t] = b[t];
      else w[t] = m_sig1(w[t-2]) + w[t-7] + m_sig0(w[t-15]) + w[t-16];
      e.word = w[t];
      e.idx  = 7'(t);
      sb_q.push_back(e);
    end
  endtask

  task automatic rand_block(output blk_t b);
    for (int i = 0; i < 16; i++) b[i] = {$urandom, $urandom};
  endtask

  // Scoreboard: every output handshake pops one expected word.
  always @(negedge g_clk) begin
    exp_t e;
    if (g_resetn && !flush && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL stray_output: got idx %0d word %h, required no output", out_idx, out_word);
      end else begin
        e = sb_q.pop_front();
        n_vec++;
        if (out_word !== e.word) begin
          n_bad++;
          $display("FAIL sb_word[%0d]: got %h, required %h", e.idx, out_word, e.word);
        end
        n_vec++;
        if (out_idx !== e.idx) begin
          n_bad++;
          $display("FAIL sb_idx: got %0d, required %0d", out_idx, e.idx);
        end
        n_vec++;
        if (out_last !== (e.idx == 7'd79)) begin
          n_bad++;
          $display("FAIL sb_last[%0d]: got %b, required %b", e.idx, out_last, e.idx == 7'd79);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the last word.
  task automatic send_words(input blk_t b, input int first, input int last);
    int k;
    for (int i = first; i <= last; i++) begin
      in_valid = 1'b1;
      in_word  = b[i];
      k = 0;
      do begin
        @(negedge g_clk);
        k++;
      end while (!in_ready && k < 200);
      if (!in_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL in_handshake[%0d]: in_ready=%b after %0d cycles, required 1", i, in_ready, k);
      end
      @(posedge g_clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((sb_q.size() != 0 || out_valid) && k < 2000) begin
      @(negedge g_clk);
      k++;
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb_q.size());
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    #2;
    n_vec++;
    if ({in_ready, out_valid, out_last, busy, out_idx} !== 11'd0 || out_word !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b last=%b busy=%b idx=%0d word=%h, required all 0",
               in_ready, out_valid, out_last, busy, out_idx, out_word);
    end
    #10 g_resetn = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b, required 0", in_ready);
    end
    @(posedge g_clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b vld=%b, required 1 0 0",
               in_ready, busy, out_valid);
    end
  endtask

  task automatic test_abc();
    blk_t b;
    int   k = 0;
    bit   seen_last = 0;
    b = '{default: '0};
    b[0]  = 64'h6162638000000000;
    b[15] = 64'h18;
    out_ready = 1'b1;
    push_expected(b);
    send_words(b, 0, 14);
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abc_load_state: vld=%b busy=%b, required 0 1", out_valid, busy);
    end
    send_words(b, 15, 15);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== 7'd0) begin
      n_bad++;
      $display("FAIL abc_latency: vld=%b rdy=%b idx=%0d, required 1 0 0", out_valid, in_ready, out_idx);
    end
    while (out_valid && k < 200) begin
      @(negedge g_clk);
      k++;
      if (out_valid && out_idx == 7'd16) begin
        n_vec++;
        if (out_word !== 64'h6162638000000000) begin
          n_bad++;
          $display("FAIL abc_w16: got %h, required 6162638000000000", out_word);
        end
      end
      if (out_valid && out_idx == 7'd17) begin
        n_vec++;
        if (out_word !== 64'h00030000000000C0) begin
          n_bad++;
          $display("FAIL abc_w17: got %h, required 00030000000000c0", out_word);
        end
      end
      if (out_valid && out_last) seen_last = (out_idx == 7'd79);
    end
    n_vec++;
    if (!seen_last) begin
      n_bad++;
      $display("FAIL abc_last: out_last at idx 79 seen=%b, required 1", seen_last);
    end
    drain("abc");
  endtask

  task automatic test_stall();
    blk_t        b;
    bit          prev_stall = 0;
    logic [63:0] pw = '0;
    logic [6:0]  pi = '0;
    logic        pl = 1'b0;
    int          k = 0;
    b = '{default: '0};
    b[0]  = 64'h6162638000000000;
    b[15] = 64'h18;
    out_ready = 1'b0;
    push_expected(b);
    send_words(b, 0, 15);
    while ((sb_q.size() != 0 || out_valid) && k < 1000) begin
      @(negedge g_clk);
      k++;
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_word !== pw || out_idx !== pi || out_last !== pl) begin
          n_bad++;
          $display("FAIL stall_hold: got vld=%b idx=%0d word=%h, required 1 idx=%0d word=%h",
                   out_valid, out_idx, out_word, pi, pw);
        end
      end
      prev_stall = out_valid && !out_ready;
      pw = out_word;
      pi = out_idx;
      pl = out_last;
      @(posedge g_clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_back_to_back();
    blk_t a;
    blk_t b;
    int   k = 0;
    bit   done = 0;
    rand_block(a);
    rand_block(b);
    out_ready = 1'b1;
    push_expected(a);
    send_words(a, 0, 15);
    in_valid = 1'b1;
    in_word  = b[0];
    while (!done && k < 200) begin
      @(negedge g_clk);
      k++;
      if (out_valid) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_ready_in_expand[%0d]: got %b, required 0", out_idx, in_ready);
        end
      end
      if (out_valid && out_idx == 7'd79) done = 1;
    end
    push_expected(b);
    @(posedge g_clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_restart: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge g_clk);
    #1;
    send_words(b, 1, 15);
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    blk_t b;
    int   k = 0;
    rand_block(b);
    out_ready = 1'b1;
    push_expected(b);
    send_words(b, 0, 15);
    while (!(out_valid && out_idx == 7'd40) && k < 200) begin
      @(negedge g_clk);
      k++;
    end
    n_vec++;
    if (out_idx !== 7'd40) begin
      n_bad++;
      $display("FAIL rst_reach_40: got idx %0d, required 40", out_idx);
    end
    #2 g_resetn = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_last, busy, out_idx} !== 11'd0 || out_word !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: rdy=%b vld=%b last=%b busy=%b idx=%0d word=%h, required all 0",
               in_ready, out_valid, out_last, busy, out_idx, out_word);
    end
    sb_q.delete();
    @(negedge g_clk);
    #1 g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
    rand_block(b);
    push_expected(b);
    send_words(b, 0, 15);
    drain("rst_mid");
  endtask

  task automatic test_flush();
    blk_t b;
    int   k = 0;
    rand_block(b);
    out_ready = 1'b1;
    send_words(b, 0, 6);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_word  = b[7];
    @(posedge g_clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_load: busy=%b vld=%b rdy=%b, required 0 0 1", busy, out_valid, in_ready);
    end
    rand_block(b);
    push_expected(b);
    send_words(b, 0, 15);
    while (!(out_valid && out_idx == 7'd20) && k < 200) begin
      @(negedge g_clk);
      k++;
    end
    @(posedge g_clk);
    #1;
    flush = 1'b1;
    @(posedge g_clk);
    #1;
    flush = 1'b0;
    sb_q.delete();
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 7'd0) begin
      n_bad++;
      $display("FAIL flush_expand: busy=%b vld=%b rdy=%b idx=%0d, required 0 0 1 0",
               busy, out_valid, in_ready, out_idx);
    end
    repeat (5) @(posedge g_clk);
    #1;
    rand_block(b);
    push_expected(b);
    send_words(b, 0, 15);
    drain("flush");
  endtask

  task automatic test_all_ones();
    blk_t b;
    b = '{default: 64'hFFFFFFFFFFFFFFFF};
    out_ready = 1'b1;
    push_expected(b);
    send_words(b, 0, 15);
    drain("ones");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    test_all_ones();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
